instr_decode_stage: RTL and testbench

Registered, parametrised RISC-V instruction decode stage for the pipelined processor, sitting between fetch and register-read/execute. It splits any base-ISA instruction into fields and generates the sign-extended immediate for all six formats (R/I/S/B/U/J), not just R-type. It flags illegal opcodes, zeroes fields that are unused by the decoded format, and carries the PC. A valid/ready handshake with a 2-entry skid buffer gives full throughput under back-pressure, and a flush input supports branch redirects.

---
 rtl/instr_decode_stage.sv | 174 +++++++++++++++++
 tb/tb_instr_decode_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - registered RV32/RV64 decode stage with 2-entry skid buffer
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 kill both buffered entries at the next edge
//   in_valid/in_ready     upstream handshake; in_instr, in_pc are the payload
//   out_valid/out_ready   downstream handshake
//   out_pc, opcode, rd, funct3, rs1, rs2, funct7, imm, fmt, illegal
//                         decoded fields of the main entry
//                         fields unused by the format are 0
//                         fmt: 0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
module instr_decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t          dec;
  entry_t          main_q, main_d;
  entry_t          skid_q, skid_d;
  logic            main_valid_q, main_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic            accept;
  logic [2:0]      fmt_c;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;

  // Format classification; RV64 W-opcodes only exist when XLEN is 64.
  always_comb begin
    fmt_c = FMT_ILL;
    if (in_instr[1:0] == 2'b11) begin
      case (in_instr[6:0])
        7'b0110011: fmt_c = FMT_R;
        7'b0111011: fmt_c = (XLEN == 64) ? FMT_R : FMT_ILL;
        7'b0010011, 7'b0000011, 7'b1100111,
        7'b1110011, 7'b0001111: fmt_c = FMT_I;
        7'b0011011: fmt_c = (XLEN == 64) ? FMT_I : FMT_ILL;
        7'b0100011: fmt_c = FMT_S;
        7'b1100011: fmt_c = FMT_B;
        7'b0110111, 7'b0010111: fmt_c = FMT_U;
        7'b1101111: fmt_c = FMT_J;
        default:    fmt_c = FMT_ILL;
      endcase
    end
  end

  // Every immediate fits in 32 bits sign-extended; widen to XLEN afterwards.
  always_comb begin
    imm32 = '0;
    case (fmt_c)
      FMT_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U: imm32 = {in_instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    imm_ext        = {XLEN{imm32[31]}};
    imm_ext[31:0]  = imm32;
  end

  always_comb begin
    dec         = '0;
    dec.opcode  = in_instr[6:0];
    dec.pc      = in_pc;
    dec.fmt     = fmt_c;
    dec.illegal = (fmt_c == FMT_ILL);
    dec.imm     = imm_ext;
    if (fmt_c inside {FMT_R, FMT_I, FMT_U, FMT_J}) dec.rd     = in_instr[11:7];
    if (fmt_c inside {FMT_R, FMT_I, FMT_S, FMT_B}) dec.funct3 = in_instr[14:12];
    if (fmt_c inside {FMT_R, FMT_I, FMT_S, FMT_B}) dec.rs1    = in_instr[19:15];
    if (fmt_c inside {FMT_R, FMT_S, FMT_B})        dec.rs2    = in_instr[24:20];
    if (fmt_c == FMT_R)                            dec.funct7 = in_instr[31:25];
  end

  // in_ready comes straight from the skid flag, so out_ready never reaches it.
  assign accept = in_valid && !skid_valid_q;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_ready) begin
      // Skid holds the older entry, so it drains first to keep FIFO order.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_pc    = main_q.pc;
  assign opcode    = main_q.opcode;
  assign rd        = main_q.rd;
  assign funct3    = main_q.funct3;
  assign rs1       = main_q.rs1;
  assign rs2       = main_q.rs2;
  assign funct7    = main_q.funct7;
  assign imm       = main_q.imm;
  assign fmt       = main_q.fmt;
  assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - directed table-driven bench for instr_decode_stage
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        in_ready, out_valid, illegal;
  logic [31:0] out_pc, imm;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3, fmt;

  logic        in_ready_64, out_valid_64, illegal_64;
  logic [31:0] out_pc_64;
  logic [63:0] imm_64;
  logic [6:0]  opcode_64, funct7_64;
  logic [4:0]  rd_64, rs1_64, rs2_64;
  logic [2:0]  funct3_64, fmt_64;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_decode_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .fmt(fmt), .illegal(illegal)
  );

  instr_decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_64), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid_64), .out_ready(out_ready), .out_pc(out_pc_64),
    .opcode(opcode_64), .rd(rd_64), .funct3(funct3_64), .rs1(rs1_64), .rs2(rs2_64),
    .funct7(funct7_64), .imm(imm_64), .fmt(fmt_64), .illegal(illegal_64)
  );

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
  endtask

  initial begin
    //                instr         opc    rd     f3    rs1    rs2    f7     imm            fmt   ill
    vecs[0] = '{32'h002081B3, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 32'h00000000, 3'd0, 1'b0};
    vecs[1] = '{32'h402081B3, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h20, 32'h00000000, 3'd0, 1'b0};
    vecs[2] = '{32'hFFF00293, 7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'h00, 32'hFFFFFFFF, 3'd1, 1'b0};
    vecs[3] = '{32'hFE20AE23, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'h00, 32'hFFFFFFFC, 3'd2, 1'b0};
    vecs[4] = '{32'hFE208EE3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'h00, 32'hFFFFFFFC, 3'd3, 1'b0};
    vecs[5] = '{32'h123453B7, 7'h37, 5'd7, 3'd0, 5'd0, 5'd0, 7'h00, 32'h12345000, 3'd4, 1'b0};
    vecs[6] = '{32'hFF9FF0EF, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'hFFFFFFF8, 3'd5, 1'b0};
    vecs[7] = '{32'h00000000, 7'h00, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000000, 3'd7, 1'b1};
    vecs[8] = '{32'h002081B1, 7'h31, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000000, 3'd7, 1'b1};
    vecs[9] = '{32'h0010809B, 7'h1B, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000000, 3'd7, 1'b1};

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_pc", 64'(out_pc), 64'd0);
    check("reset imm", 64'(imm), 64'd0);
    check("reset fmt", 64'(fmt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back stream with out_ready high: one result per cycle.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].instr, 32'(i * 4), 1'b1, 1'b0);
      tick();
      check($sformatf("v%0d out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("v%0d out_pc", i), 64'(out_pc), 64'(i * 4));
      check($sformatf("v%0d opcode", i), 64'(opcode), 64'(vecs[i].opcode));
      check($sformatf("v%0d rd", i), 64'(rd), 64'(vecs[i].rd));
      check($sformatf("v%0d funct3", i), 64'(funct3), 64'(vecs[i].funct3));
      check($sformatf("v%0d rs1", i), 64'(rs1), 64'(vecs[i].rs1));
      check($sformatf("v%0d rs2", i), 64'(rs2), 64'(vecs[i].rs2));
      check($sformatf("v%0d funct7", i), 64'(funct7), 64'(vecs[i].funct7));
      check($sformatf("v%0d imm", i), 64'(imm), 64'(vecs[i].imm));
      check($sformatf("v%0d fmt", i), 64'(fmt), 64'(vecs[i].fmt));
      check($sformatf("v%0d illegal", i), 64'(illegal), 64'(vecs[i].illegal));
      check($sformatf("v%0d in_ready", i), 64'(in_ready), 64'd1);
    end
    // Last vector is addiw: legal only in the 64-bit instance.
    check("rv64 addiw fmt", 64'(fmt_64), 64'd1);
    check("rv64 addiw imm", imm_64, 64'h1);
    check("rv64 addiw illegal", 64'(illegal_64), 64'd0);
    check("rv64 addiw rd", 64'(rd_64), 64'd1);
    check("rv64 addiw rs1", 64'(rs1_64), 64'd1);

    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    check("drain out_valid", 64'(out_valid), 64'd0);

    // Back-pressure: out_ready low for two cycles after the first accept.
    drive(1'b1, 32'hFFF00293, 32'h0, 1'b0, 1'b0);
    tick();
    check("bp first out_pc", 64'(out_pc), 64'h0);
    check("bp first in_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 32'h002081B3, 32'h4, 1'b0, 1'b0);
    tick();
    check("bp skid in_ready", 64'(in_ready), 64'd0);
    check("bp hold out_pc 1", 64'(out_pc), 64'h0);
    check("bp hold imm 1", 64'(imm), 64'hFFFFFFFF);
    drive(1'b1, 32'hFE208EE3, 32'h8, 1'b0, 1'b0);
    tick();
    check("bp stall in_ready", 64'(in_ready), 64'd0);
    check("bp hold out_pc 2", 64'(out_pc), 64'h0);
    check("bp hold out_valid", 64'(out_valid), 64'd1);
    check("bp hold fmt", 64'(fmt), 64'd1);
    drive(1'b1, 32'hFE208EE3, 32'h8, 1'b1, 1'b0);
    tick();
    check("bp release out_pc", 64'(out_pc), 64'h4);
    check("bp release fmt", 64'(fmt), 64'd0);
    check("bp release in_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 32'hFE208EE3, 32'h8, 1'b1, 1'b0);
    tick();
    check("bp third out_pc", 64'(out_pc), 64'h8);
    check("bp third imm", 64'(imm), 64'hFFFFFFFC);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    check("bp drained", 64'(out_valid), 64'd0);

    // Flush with both entries full while in_valid is high.
    drive(1'b1, 32'h002081B3, 32'h100, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h002081B3, 32'h104, 1'b0, 1'b0);
    tick();
    check("flush pre in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h002081B3, 32'h108, 1'b0, 1'b1);
    tick();
    check("flush out_valid", 64'(out_valid), 64'd0);
    check("flush in_ready", 64'(in_ready), 64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    check("flush no ghost", 64'(out_valid), 64'd0);

    // Flush coinciding with an accept into an empty stage drops that input.
    drive(1'b1, 32'h002081B3, 32'h10C, 1'b1, 1'b1);
    tick();
    check("flush accept out_valid", 64'(out_valid), 64'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    check("flush accept no ghost", 64'(out_valid), 64'd0);

    // Asynchronous reset in the middle of a stall.
    drive(1'b1, 32'hFFF00293, 32'h200, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hFFF00293, 32'h204, 1'b0, 1'b0);
    tick();
    check("rst pre out_pc", 64'(out_pc), 64'h200);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst async out_valid", 64'(out_valid), 64'd0);
    check("rst async in_ready", 64'(in_ready), 64'd1);
    check("rst async out_pc", 64'(out_pc), 64'd0);
    check("rst async imm", 64'(imm), 64'd0);
    check("rst async rd", 64'(rd), 64'd0);
    check("rst async opcode", 64'(opcode), 64'd0);
    check("rst async fmt", 64'(fmt), 64'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst after out_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 32'h123453B7, 32'h300, 1'b1, 1'b0);
    tick();
    check("rst resume out_pc", 64'(out_pc), 64'h300);
    check("rst resume imm", 64'(imm), 64'h12345000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
